// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad front-end and the ATM controller.
// Contents:
//   KEY_* constants  : keypad codes above the decimal digits 0-9
//   entry_state_e    : keypad entry FSM states
//   MODE_PIN/MODE_AMT: entry mode select values
//   is_digit()       : true for key codes 0-9
package atm_pkg;

    localparam logic [3:0] KEY_CLEAR  = 4'd10;
    localparam logic [3:0] KEY_BACK   = 4'd11;
    localparam logic [3:0] KEY_ENTER  = 4'd12;
    localparam logic [3:0] KEY_CANCEL = 4'd13;

    localparam logic MODE_PIN = 1'b0;
    localparam logic MODE_AMT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_CONVERT = 2'd2,
        ST_HOLD    = 2'd3
    } entry_state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/atm_bcd_to_bin.sv
// Iterative decimal-to-binary converter: folds one decimal digit per clock
// into a 32-bit accumulator (acc = acc*10 + d), most significant digit first.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   start     : load; conversion of 'count' digits begins on the next clock
//   digits    : packed digit buffer, digit i at bits [4i+3:4i], MSD at count-1
//   count     : number of digits to convert (1..MAX_DIGITS)
//   done      : one-cycle pulse, acc holds the final value from then on
//   acc       : binary result
module atm_bcd_to_bin #(
    parameter int MAX_DIGITS = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [4*MAX_DIGITS-1:0]   digits,
    input  logic [3:0]                count,
    output logic                      done,
    output logic [31:0]               acc
);

    logic       busy;
    logic [3:0] idx;
    logic [3:0] remaining;
    logic [3:0] digit;

    always_comb begin
        digit = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (idx == 4'(i)) digit = digits[i*4 +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            idx       <= '0;
            remaining <= '0;
            acc       <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc       <= '0;
                idx       <= count - 4'd1;
                remaining <= count;
                busy      <= (count != 4'd0);
                done      <= (count == 4'd0);
            end else if (busy) begin
                // x10 as shift-and-add
                acc       <= (acc << 3) + (acc << 1) + {28'd0, digit};
                idx       <= idx - 4'd1;
                remaining <= remaining - 4'd1;
                if (remaining == 4'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad front-end for the ATM controller: buffers decimal key presses with
// backspace/clear/cancel/inactivity timeout, converts the buffered digits to a
// 16-bit PIN or 32-bit amount on ENTER and presents the result.
// Handshake: a result is offered with pin_valid/amount_valid; value and valid
// hold steady until a clock edge where out_ready=1, which completes the
// transfer. A key is consumed only on an edge where key_valid=1 and key_ready=1.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   key_valid/key_code : key strobe and code (0-9 digit, 10-13 commands)
//   key_ready          : keys accepted (IDLE and ENTRY)
//   mode               : 0 = PIN, 1 = amount, latched on the first digit
//   out_ready          : controller accepts the presented value
//   pin/pin_valid      : PIN result
//   amount/amount_valid: amount result
//   digit_count        : digits buffered, for the display
//   err/timeout/cancel : one-cycle event pulses
//   state_dbg          : current FSM state (entry_state_e encoding)
module atm_keypad_entry
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS     = 4,
    parameter int AMT_DIGITS     = 9,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        mode,
    input  logic        out_ready,
    output logic        key_ready,
    output logic [15:0] pin,
    output logic [31:0] amount,
    output logic        pin_valid,
    output logic        amount_valid,
    output logic [3:0]  digit_count,
    output logic        err,
    output logic        timeout,
    output logic        cancel,
    output logic [1:0]  state_dbg
);

    localparam int             BUF_W     = 4 * AMT_DIGITS;
    localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]     PIN_LIM   = 4'(PIN_DIGITS);
    localparam logic [3:0]     AMT_LIM   = 4'(AMT_DIGITS);
    localparam logic [TW-1:0]  IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

    entry_state_e     state;
    logic [BUF_W-1:0] digit_buf;
    logic             mode_q;
    logic [TW-1:0]    idle_cnt;

    logic             key_fire;
    logic [3:0]       limit;
    logic             enter_ok;
    logic             conv_start;
    logic             conv_done;
    logic [31:0]      conv_acc;

    assign key_fire   = key_valid && key_ready;
    assign limit      = (mode_q == MODE_AMT) ? AMT_LIM : PIN_LIM;
    assign enter_ok   = (mode_q == MODE_PIN) ? (digit_count == PIN_LIM)
                                             : (digit_count != 4'd0);
    assign conv_start = (state == ST_ENTRY) && key_fire &&
                        (key_code == KEY_ENTER) && enter_ok;
    assign state_dbg  = state;

    atm_bcd_to_bin #(.MAX_DIGITS(AMT_DIGITS)) u_conv (
        .clk    (clk),
        .rst    (rst),
        .start  (conv_start),
        .digits (digit_buf),
        .count  (digit_count),
        .done   (conv_done),
        .acc    (conv_acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            digit_buf    <= '0;
            digit_count  <= '0;
            mode_q       <= MODE_PIN;
            idle_cnt     <= '0;
            key_ready    <= 1'b1;
            pin          <= '0;
            amount       <= '0;
            pin_valid    <= 1'b0;
            amount_valid <= 1'b0;
            err          <= 1'b0;
            timeout      <= 1'b0;
            cancel       <= 1'b0;
        end else begin
            err     <= 1'b0;
            timeout <= 1'b0;
            cancel  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_fire && is_digit(key_code)) begin
                        digit_buf   <= BUF_W'(key_code);
                        digit_count <= 4'd1;
                        mode_q      <= mode;
                        idle_cnt    <= '0;
                        state       <= ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    // A consumed key on the terminal idle cycle wins over timeout.
                    if (key_fire) begin
                        idle_cnt <= '0;
                        if (is_digit(key_code)) begin
                            if (digit_count < limit) begin
                                digit_buf   <= {digit_buf[BUF_W-5:0], key_code};
                                digit_count <= digit_count + 4'd1;
                            end
                        end else begin
                            case (key_code)
                                KEY_CLEAR: begin
                                    digit_buf   <= '0;
                                    digit_count <= '0;
                                end
                                KEY_BACK: begin
                                    if (digit_count != 4'd0) begin
                                        digit_buf   <= {4'd0, digit_buf[BUF_W-1:4]};
                                        digit_count <= digit_count - 4'd1;
                                    end
                                end
                                KEY_CANCEL: begin
                                    cancel      <= 1'b1;
                                    digit_buf   <= '0;
                                    digit_count <= '0;
                                    mode_q      <= MODE_PIN;
                                    state       <= ST_IDLE;
                                end
                                KEY_ENTER: begin
                                    if (enter_ok) begin
                                        key_ready <= 1'b0;
                                        state     <= ST_CONVERT;
                                    end else begin
                                        err         <= 1'b1;
                                        digit_buf   <= '0;
                                        digit_count <= '0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        timeout     <= 1'b1;
                        digit_buf   <= '0;
                        digit_count <= '0;
                        mode_q      <= MODE_PIN;
                        idle_cnt    <= '0;
                        state       <= ST_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                ST_CONVERT: begin
                    if (conv_done) begin
                        if (mode_q == MODE_PIN) begin
                            pin       <= conv_acc[15:0];
                            pin_valid <= 1'b1;
                        end else begin
                            amount       <= conv_acc;
                            amount_valid <= 1'b1;
                        end
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        pin_valid    <= 1'b0;
                        amount_valid <= 1'b0;
                        digit_buf    <= '0;
                        digit_count  <= '0;
                        mode_q       <= MODE_PIN;
                        key_ready    <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
